projectile_launcher: RTL
========================

Name: projectile_launcher

Overview:
- Producer side of the circular collision check: spawns a single projectile at the player, advances it once per frame and drives its centre and radius to the hitbox comparator.
- Consumes the comparator's contact result, reports a hit, despawns the projectile, then enforces a reload cooldown.
- Sits between the player/keyboard control logic and the hitbox comparator, in the game-logic clock domain.

Parameters:
- SPEED, 4, pixels moved per frame tick (1..15).
- RADIUS, 4, projectile radius driven on Coverage while active.
- COOLDOWN, 30, frame ticks in COOLDOWN before the next shot is allowed (0 allowed).
- X_MAX, 639, rightmost legal projectile X.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- frame_clk, input, 1, raw frame strobe. Its rising edge, detected in the Clk domain, is a "frame tick".
- fire, input, 1, level request to shoot.
- facing_left, input, 1, direction sampled at spawn: 1 = move toward X=0.
- Player_X, input, 10, player centre X, sampled at spawn.
- Player_Y, input, 10, player centre Y, sampled at spawn.
- contact, input, 1, hitbox result for the current Proj_X/Proj_Y/Coverage.
- Proj_X, output, 10, projectile centre X, to hitbox Obj_X.
- Proj_Y, output, 10, projectile centre Y, to hitbox Obj_Y.
- Coverage, output, 10, RADIUS while active, else 0.
- active, output, 1, projectile in flight.
- hit, output, 1, one-Clk pulse on a registered contact.
- ready, output, 1, high in IDLE (a shot may be fired).

Behaviour:
- Reset, synchronous, Clk edge with Reset=1, any state including mid-flight:
  - State = IDLE; Proj_X = Proj_Y = 0; Coverage = 0; active = 0; hit = 0; ready = 1.
  - Cooldown counter = 0; frame edge detector history = 0, so no spurious tick on the first cycle after reset.
- Frame tick = frame_clk registered once and compared with its previous registered value (0->1). One Clk of latency after the edge.
- States: IDLE, FLIGHT, COOLDOWN. All outputs are registered.
- IDLE:
  - ready = 1.
  - fire = 1 on a Clk edge: latch Player_X/Player_Y into Proj_X/Proj_Y and latch facing_left. Set active = 1 and Coverage = RADIUS; ready drops. Next state FLIGHT.
  - Result is visible the cycle after fire is sampled.
- FLIGHT, evaluated every Clk. Priority: contact > off-screen > move.
  - contact = 1: hit = 1 for exactly one cycle; active = 0; Coverage = 0; load cooldown counter = COOLDOWN; go COOLDOWN. Proj_X/Proj_Y hold their last values.
  - Otherwise, on a frame tick, moving right and Proj_X + SPEED > X_MAX (compare at 11 bits): despawn with no hit and go COOLDOWN.
  - Otherwise, on a frame tick, moving left and Proj_X < SPEED: despawn the same way. X must never wrap below 0.
  - Otherwise, on a frame tick: Proj_X += SPEED (right) or -= SPEED (left). Proj_Y is constant.
  - contact and a frame tick in the same cycle: the hit wins and no move occurs.
- COOLDOWN:
  - Counter decrements on each frame tick.
  - When counter = 0 at a Clk edge, go IDLE and set ready = 1. With COOLDOWN = 0, IDLE is reached one Clk after entering.
- Ignored inputs:
  - contact is ignored outside FLIGHT, so hit never fires otherwise.
  - fire is ignored outside IDLE and does not queue.
  - fire held continuously re-fires on the first IDLE cycle.
  - Player_X/Y and facing_left changes during flight have no effect.

Test Plan:
- Spawn: Reset; Player=(100,200), facing_left=0, fire for 1 Clk -> next cycle Proj=(100,200), Coverage=4, active=1, ready=0. After 3 frame ticks, Proj_X=112.
- Hit: in FLIGHT, assert contact 1 Clk together with a frame tick -> hit high exactly 1 cycle, Proj_X unchanged, active=0, Coverage=0. ready returns after 30 ticks, not 29.
- Right edge: spawn at X=632, moving right -> tick1 Proj_X=636; tick2 despawns (636+4=640>639) with hit=0 and enters COOLDOWN.
- Left edge: spawn at X=6, facing_left=1 -> tick1 Proj_X=2; tick2 despawns (2<4), never reaches 1022.
- Cooldown and queuing: COOLDOWN=0 build; hold fire constantly -> re-spawn one Clk after each despawn. Default build: fire pulses during COOLDOWN produce no spawn.
- Reset mid-flight: Reset asserted while Proj_X=300 -> next cycle all outputs zero, ready=1. A stray contact afterwards produces no hit.

Source files
------------

// File: rtl/projectile_launcher.sv
// Single-projectile launcher: spawns at the player, advances once per frame tick,
// drives centre/radius to the hitbox comparator and enforces a reload cooldown.
module projectile_launcher #(
    parameter int SPEED    = 4,
    parameter int RADIUS   = 4,
    parameter int COOLDOWN = 30,
    parameter int X_MAX    = 639
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       facing_left,
    input  logic [9:0] Player_X,
    input  logic [9:0] Player_Y,
    input  logic       contact,
    output logic [9:0] Proj_X,
    output logic [9:0] Proj_Y,
    output logic [9:0] Coverage,
    output logic       active,
    output logic       hit,
    output logic       ready
);

    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLIGHT,
        ST_COOLDOWN
    } state_t;

    state_t     state, state_next;
    logic       frame_q, frame_prev;
    logic       frame_tick;
    logic       dir_left, dir_left_next;
    logic [CNT_W-1:0] cool_cnt, cool_cnt_next;
    logic [9:0] proj_x_next, proj_y_next, coverage_next;
    logic       active_next, hit_next, ready_next;
    logic [10:0] right_sum;

    assign frame_tick = frame_q & ~frame_prev;
    assign right_sum  = {1'b0, Proj_X} + 11'(SPEED);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next    = state;
        dir_left_next = dir_left;
        cool_cnt_next = cool_cnt;
        proj_x_next   = Proj_X;
        proj_y_next   = Proj_Y;
        coverage_next = Coverage;
        active_next   = active;
        hit_next      = 1'b0;
        ready_next    = ready;

        case (state)
            ST_IDLE: begin
                ready_next = 1'b1;
                if (fire) begin
                    proj_x_next   = Player_X;
                    proj_y_next   = Player_Y;
                    dir_left_next = facing_left;
                    active_next   = 1'b1;
                    coverage_next = 10'(RADIUS);
                    ready_next    = 1'b0;
                    state_next    = ST_FLIGHT;
                end
            end
            ST_FLIGHT: begin
                // A contact outranks the frame tick, so a hit never moves the projectile.
                if (contact) begin
                    hit_next      = 1'b1;
                    active_next   = 1'b0;
                    coverage_next = '0;
                    cool_cnt_next = CNT_W'(COOLDOWN);
                    state_next    = ST_COOLDOWN;
                end else if (frame_tick) begin
                    if ((!dir_left && (right_sum > 11'(X_MAX))) ||
                        (dir_left && (Proj_X < 10'(SPEED)))) begin
                        active_next   = 1'b0;
                        coverage_next = '0;
                        cool_cnt_next = CNT_W'(COOLDOWN);
                        state_next    = ST_COOLDOWN;
                    end else if (dir_left) begin
                        proj_x_next = Proj_X - 10'(SPEED);
                    end else begin
                        proj_x_next = Proj_X + 10'(SPEED);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt == '0) begin
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (frame_tick) begin
                    cool_cnt_next = cool_cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            frame_q    <= 1'b0;
            frame_prev <= 1'b0;
            dir_left   <= 1'b0;
            cool_cnt   <= '0;
            Proj_X     <= '0;
            Proj_Y     <= '0;
            Coverage   <= '0;
            active     <= 1'b0;
            hit        <= 1'b0;
            ready      <= 1'b1;
        end else begin
            state      <= state_next;
            frame_q    <= frame_clk;
            frame_prev <= frame_q;
            dir_left   <= dir_left_next;
            cool_cnt   <= cool_cnt_next;
            Proj_X     <= proj_x_next;
            Proj_Y     <= proj_y_next;
            Coverage   <= coverage_next;
            active     <= active_next;
            hit        <= hit_next;
            ready      <= ready_next;
        end
    end

endmodule
